// File: rtl/aes_req_sched.sv
`default_nettype none
// ============================================================================
// Module   : aes_req_sched
// Brief    : Round-robin scheduler sharing one aes_core among NumReq requesters,
//            with key sideload, start/idle tracking and a stuck-busy watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module aes_req_sched #(
    parameter int NumReq        = 4,
    parameter int StartWindow   = 8,
    parameter int TimeoutCycles = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumReq-1:0]     req_i,
    input  logic [NumReq*128-1:0] key_i,
    output logic [NumReq-1:0]     gnt_o,
    output logic [NumReq-1:0]     done_o,
    output logic                  err_o,
    output logic                  aes_key_valid_o,
    output logic [127:0]          aes_key_o,
    output logic                  aes_start_o,
    input  logic                  aes_idle_i,
    output logic                  busy_o,
    output logic                  alert_o
);

    localparam int PtrW = $clog2(NumReq);
    localparam int CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] C_SW_LAST  = CntW'(StartWindow - 1);
    localparam logic [CntW-1:0] C_TO_LAST  = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] C_CNT_MAX  = '1;
    localparam logic [PtrW-1:0] C_PTR_LAST = PtrW'(NumReq - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_KEY       = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_IDLE = 3'd4,
        ST_DONE      = 3'd5,
        ST_LOCKED    = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [PtrW-1:0]   owner_q, owner_d;
    logic [127:0]      key_q, key_d;
    logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic              err_q, err_d;

    logic [NumReq-1:0] gnt_q, gnt_d;
    logic [NumReq-1:0] done_q, done_d;
    logic              err_out_q, err_out_d;
    logic              key_valid_q, key_valid_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              alert_q, alert_d;

    logic [127:0]      key_arr [NumReq];
    logic [PtrW-1:0]   pick;
    logic [PtrW:0]     sum;
    logic              found;
    logic [NumReq-1:0] owner_oh;

    for (genvar g = 0; g < NumReq; g++) begin : g_key
        assign key_arr[g] = key_i[g*128 +: 128];
    end

    // First asserted request at or after the pointer, wrapping around.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        sum   = '0;
        for (int k = 0; k < NumReq; k++) begin
            sum = {1'b0, ptr_q} + (PtrW+1)'(k);
            if (sum >= (PtrW+1)'(NumReq)) begin
                sum = sum - (PtrW+1)'(NumReq);
            end
            if (!found && req_i[sum[PtrW-1:0]]) begin
                found = 1'b1;
                pick  = sum[PtrW-1:0];
            end
        end
    end

    assign cnt_inc = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + CntW'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (found && aes_idle_i) begin
                    owner_d = pick;
                    key_d   = key_arr[pick];
                    state_d = ST_KEY;
                end
            end
            ST_KEY: state_d = ST_START;
            ST_START: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!aes_idle_i) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_IDLE;
                end else if (cnt_q == C_SW_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT_IDLE: begin
                if (aes_idle_i) begin
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == C_TO_LAST) begin
                    state_d = ST_LOCKED;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: begin
                ptr_d   = (owner_q == C_PTR_LAST) ? '0 : owner_q + PtrW'(1);
                state_d = ST_IDLE;
            end
            ST_LOCKED: state_d = ST_LOCKED;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered.
    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_d] = 1'b1;
        gnt_d       = (state_d == ST_KEY)  ? owner_oh : '0;
        done_d      = (state_d == ST_DONE) ? owner_oh : '0;
        err_out_d   = (state_d == ST_DONE) && err_d;
        key_valid_d = (state_d == ST_KEY);
        start_d     = (state_d == ST_START);
        busy_d      = (state_d != ST_IDLE);
        alert_d     = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            key_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_out_q   <= 1'b0;
            key_valid_q <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            alert_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            key_q       <= key_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_out_q   <= err_out_d;
            key_valid_q <= key_valid_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            alert_q     <= alert_d;
        end
    end

    assign gnt_o           = gnt_q;
    assign done_o          = done_q;
    assign err_o           = err_out_q;
    assign aes_key_valid_o = key_valid_q;
    assign aes_key_o       = key_q;
    assign aes_start_o     = start_q;
    assign busy_o          = busy_q;
    assign alert_o         = alert_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_req_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_req_sched
// Brief    : Self-checking bench for aes_req_sched with an aes_core stand-in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_req_sched;

    localparam int NR = 4;
    localparam int SW = 8;
    localparam int TO = 1024;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NR-1:0]     req_i;
    logic [NR*128-1:0] key_i;
    logic [NR-1:0]     gnt_o, done_o;
    logic              err_o, aes_key_valid_o, aes_start_o, aes_idle_i, busy_o, alert_o;
    logic [127:0]      aes_key_o;

    always #5 clk_i = ~clk_i;

    aes_req_sched #(.NumReq(NR), .StartWindow(SW), .TimeoutCycles(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .key_i(key_i),
        .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
        .aes_key_valid_o(aes_key_valid_o), .aes_key_o(aes_key_o),
        .aes_start_o(aes_start_o), .aes_idle_i(aes_idle_i),
        .busy_o(busy_o), .alert_o(alert_o)
    );

    int checks = 0;
    int errors = 0;

    // Core stand-in: mode 0 normal, 1 never acknowledges start, 2 hangs busy.
    int core_drop = 2, core_len = 20, core_mode = 0;
    int core_delay = 0, core_left = 0;
    bit core_active = 1'b0, force_busy = 1'b0;
    assign aes_idle_i = !(core_active || force_busy);

    initial forever begin
        @(posedge clk_i); #2;
        if (!rst_ni) begin
            core_active = 1'b0; core_delay = 0; core_left = 0;
        end else if (aes_start_o && core_mode != 1) begin
            core_delay = core_drop;
        end else if (core_delay > 0) begin
            core_delay--;
            if (core_delay == 0) begin core_active = 1'b1; core_left = core_len; end
        end else if (core_active && core_mode != 2) begin
            core_left--;
            if (core_left == 0) core_active = 1'b0;
        end
    end

    logic [127:0] keys [NR];
    int ptr_m = 0;

    function automatic int rr_pick(input logic [NR-1:0] r, input int p);
        for (int k = 0; k < NR; k++) if (r[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i); #1;
    endtask

    task automatic new_keys();
        for (int i = 0; i < NR; i++) begin
            keys[i] = {$urandom, $urandom, $urandom, $urandom};
            key_i[i*128 +: 128] = keys[i];
        end
    endtask

    task automatic run_job(input logic [NR-1:0] pat, input int drop, input int len,
                           input int mode, input logic [NR-1:0] after, input string tag);
        int own, n, m;
        logic [127:0] k;
        core_drop = drop; core_len = len; core_mode = mode;
        own = rr_pick(pat, ptr_m);
        req_i = pat;
        n = 0;
        do begin step(); n++; end while (gnt_o == '0 && n < 40);
        chk({tag, " gnt"}, gnt_o, 128'(1) << own);
        chk({tag, " gnt_lat"}, n, 1);
        chk({tag, " key_valid"}, aes_key_valid_o, 1);
        chk({tag, " key"}, aes_key_o, keys[own]);
        k = keys[own];
        req_i = after;
        new_keys();
        step();
        chk({tag, " start"}, {aes_start_o, gnt_o, aes_key_valid_o}, {1'b1, {NR{1'b0}}, 1'b0});
        chk({tag, " key_hold"}, aes_key_o, k);
        m = 0;
        do begin step(); m++; end while (done_o == '0 && m < 2000);
        chk({tag, " done"}, {done_o, err_o}, {NR'(1) << own, mode == 1});
        chk({tag, " done_lat"}, m, (mode == 1) ? SW + 1 : drop + len + 1);
        ptr_m = (own + 1) % NR;
        step();
        chk({tag, " idle"}, {done_o, busy_o, alert_o}, '0);
    endtask

    initial begin
        int m;
        bit bad;
        req_i = '0; key_i = '0; rst_ni = 1'b1;
        #3 rst_ni = 1'b0;
        step(); step();
        chk("reset_outs", {gnt_o, done_o, err_o, aes_key_valid_o, aes_start_o, busy_o, alert_o}, '0);
        chk("reset_key", aes_key_o, '0);
        rst_ni = 1'b1;
        new_keys();
        step();

        // Fairness: 0,1,2,3,0 then 1,3,1
        for (int j = 0; j < 5; j++) run_job(4'b1111, 2, 5, 0, 4'b1111, "fair_all");
        for (int j = 0; j < 3; j++) run_job(4'b1010, 2, 5, 0, 4'b1010, "fair_1010");
        req_i = '0;

        // Single job with fixed key
        keys[2] = 128'h0123456789abcdeffedcba9876543210;
        key_i[2*128 +: 128] = keys[2];
        run_job(4'b0100, 2, 20, 0, 4'b0000, "single");

        // Start never acknowledged, then the next request must still be served
        run_job(4'b0001, 2, 20, 1, 4'b0000, "noack");
        chk("noack_alert", alert_o, 0);
        run_job(4'b0010, 3, 4, 0, 4'b0000, "after_noack");

        // Core busy at request; a request dropped before grant is not served
        force_busy = 1'b1;
        req_i = 4'b0001;
        bad = 1'b0;
        for (int j = 0; j < 3; j++) begin step(); bad |= (gnt_o != '0); end
        req_i = '0;
        step();
        force_busy = 1'b0;
        for (int j = 0; j < 4; j++) begin step(); bad |= (gnt_o != '0); end
        chk("busy_no_gnt", bad, 0);
        force_busy = 1'b1;
        req_i = 4'b0100;
        bad = 1'b0;
        for (int j = 0; j < 4; j++) begin step(); bad |= (gnt_o != '0); end
        chk("busy_hold_gnt", bad, 0);
        force_busy = 1'b0;
        run_job(4'b0100, 2, 6, 0, 4'b0000, "busy_release");

        // Randomized jobs
        for (int j = 0; j < 20; j++) begin
            run_job(NR'($urandom_range(1, 15)), $urandom_range(1, 7), $urandom_range(1, 30),
                    ($urandom_range(0, 4) == 0) ? 1 : 0, NR'($urandom_range(0, 15)), "rand");
        end
        req_i = '0;

        // Reset in WAIT_IDLE
        core_drop = 2; core_len = 100; core_mode = 0;
        req_i = 4'b1000;
        m = 0;
        do begin step(); m++; end while (!aes_start_o && m < 40);
        req_i = '0;
        bad = 1'b0;
        for (int j = 0; j < 10; j++) begin step(); bad |= (done_o != '0); end
        rst_ni = 1'b0;
        #1;
        chk("midrst_outs", {gnt_o, done_o, err_o, aes_key_valid_o, aes_start_o, busy_o, alert_o, bad}, '0);
        chk("midrst_key", aes_key_o, '0);
        step(); step();
        rst_ni = 1'b1;
        ptr_m = 0;
        step();
        run_job(4'b1010, 2, 8, 0, 4'b0000, "post_rst");

        // Hang: core stays busy forever after start
        core_drop = 2; core_len = 1; core_mode = 2;
        req_i = 4'b0001;
        m = 0;
        do begin step(); m++; end while (!aes_start_o && m < 40);
        req_i = '0;
        chk("hang_start", aes_start_o, 1);
        m = 0;
        bad = 1'b0;
        do begin step(); m++; bad |= (done_o != '0); end while (!alert_o && m < 1100);
        chk("hang_lat", m, 2 + 1 + TO);
        chk("hang_no_done", bad, 0);
        bad = 1'b0;
        for (int j = 0; j < 257; j++) begin
            req_i = NR'($urandom_range(1, 15));
            step();
            bad |= (gnt_o != '0) || aes_start_o || aes_key_valid_o || (done_o != '0) || !alert_o;
        end
        req_i = '0;
        chk("locked_quiet", bad, 0);
        chk("locked_state", {alert_o, busy_o}, 2'b11);
        rst_ni = 1'b0;
        #1;
        chk("alert_clear", {alert_o, busy_o}, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_req_sched.md
Name: aes_req_sched

Overview:
- Round-robin scheduler that shares one aes_core among NumReq software/hardware requesters.
- For each granted job it sideloads the requester's 128-bit key, pulses start, and tracks the core through busy back to idle.
- A hang watchdog catches a core that never returns to idle (stuck-busy DoS). It locks the scheduler and raises a sticky alert.
- Sits between the requester fabric and the aes_core sideload-key / ctrl.start / status.idle interface.

Parameters:
- NumReq, 4, number of requesters (2..8).
- StartWindow, 8, max cycles allowed after start for aes_idle_i to drop.
- TimeoutCycles, 1024, max cycles allowed in busy before lockout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NumReq  per-requester job request; level, held until gnt_o
- key_i  in  NumReq*128  per-requester key; slice i = key_i[i*128 +: 128]
- gnt_o  out  NumReq  one-hot grant pulse
- done_o  out  NumReq  one-hot completion pulse
- err_o  out  1  qualifies done_o: 1 = job failed (start not acknowledged)
- aes_key_valid_o  out  1  sideload key valid to aes_core
- aes_key_o  out  128  sideload key to aes_core
- aes_start_o  out  1  start strobe (drives ctrl.start.q and ctrl.start.qe)
- aes_idle_i  in  1  aes_core status.idle
- busy_o  out  1  scheduler not in IDLE
- alert_o  out  1  sticky hang alert, held until reset

Behaviour:
- Reset (async, rst_ni=0):
  - State IDLE, RR pointer 0, owner 0, counter 0.
  - All outputs 0, aes_key_o included.
- All outputs are registered (state-decoded).
- IDLE:
  - If |req_i and aes_idle_i=1, pick the first asserted req at or after the pointer, wrapping mod NumReq.
  - Latch owner and key_i[owner] at that edge, then go to KEY.
  - If aes_idle_i=0, do not grant.
- KEY (1 cycle):
  - gnt_o[owner]=1, aes_key_valid_o=1, aes_key_o=latched key.
  - Go to START.
- START (1 cycle):
  - aes_start_o=1, counter cleared.
  - Go to WAIT_BUSY.
- WAIT_BUSY:
  - aes_idle_i=0 -> WAIT_IDLE, counter cleared.
  - Otherwise increment counter. When counter reaches StartWindow-1 with idle still 1, go to DONE with err flag set.
- WAIT_IDLE:
  - aes_idle_i=1 -> DONE, err flag clear.
  - Otherwise increment counter. When counter reaches TimeoutCycles-1, go to LOCKED.
- DONE (1 cycle):
  - done_o[owner]=1, err_o=err flag.
  - Pointer = (owner+1) mod NumReq. Go to IDLE.
- LOCKED:
  - Terminal until reset; alert_o=1.
  - gnt_o, done_o, aes_key_valid_o and aes_start_o stay 0. req_i is ignored.
  - The owner never receives done_o.
- Latency: req sampled at edge N with the core idle gives gnt/key_valid in cycle N+1 and start in N+2.
- Minimum job: done_o arrives 1 cycle after the edge where aes_idle_i returns to 1.
- Timeout: the lockout edge comes exactly TimeoutCycles clocks after entering WAIT_IDLE.
- Counter width is $clog2(TimeoutCycles+1) and it saturates (it never wraps).
- aes_key_o keeps its last value after KEY. busy_o=1 in every state except IDLE.
- Boundary conditions:
  - A req dropped before grant is not served.
  - req changes after grant are ignored until DONE.
  - A key_i change after the IDLE latch edge has no effect.
  - Reset mid-operation aborts immediately with no done_o, and clears alert_o.

Test Plan:
- Single job: req_i=4'b0100, key 0x0123..3210. Core model drops idle 2 cycles after start and stays busy 20 cycles. Required: gnt_o=4'b0100 one cycle after req, key_valid with exact key, start the next cycle, done_o=4'b0100 with err_o=0, busy_o returns to 0.
- Fairness: req_i=4'b1111 held for 5 jobs -> grant order 0,1,2,3,0. Then req_i=4'b1010 with pointer=1 -> order 1,3,1.
- No start ack: core keeps idle=1 -> done_o pulse with err_o=1 after StartWindow (8) cycles. alert_o stays 0 and the next req is granted.
- Hang: core stays busy forever after start -> alert_o=1 exactly 1024 cycles after the WAIT_IDLE entry. Then 257 further reqs produce no gnt_o or aes_start_o, and alert_o stays at 1.
- Core busy at request: aes_idle_i=0 while req_i=1 -> no grant until idle=1, then grant within 1 cycle.
- Reset mid-op: assert rst_ni=0 in WAIT_IDLE -> all outputs 0 asynchronously, no done_o. After release a new job completes normally from pointer 0.
